// File: rtl/pipe_sel_pkg.sv
// Shared constants, helpers and types for the registered channel selector.
package pipe_sel_pkg;

    localparam int MAX_CH = 16;

    // Number of 4-lane groups needed to cover n channels.
    function automatic int group_count(input int n);
        return (n + 3) / 4;
    endfunction

    // Control bits that travel alongside the data through a stage.
    typedef struct packed {
        logic valid;
        logic oor;
    } stage_ctrl_t;

endpackage

// File: rtl/sel_group4.sv
// Combinational 4:1 selector; lanes that do not exist return the pad value.
module sel_group4 #(
    parameter int WIDTH = 32
) (
    input  logic [3:0][WIDTH-1:0] x_i,
    input  logic [3:0]            lane_en_i,
    input  logic [WIDTH-1:0]      pad_i,
    input  logic [1:0]            sel_i,
    output logic [WIDTH-1:0]      y_o
);

    // Pick the addressed lane, or the pad when that lane is not populated.
    always_comb begin
        y_o = pad_i;
        if (lane_en_i[sel_i]) begin
            y_o = x_i[sel_i];
        end
    end

endmodule

// File: rtl/pipe_sel_mux.sv
// Registered N:1 channel selector with one (PIPE=0) or two (PIPE=1) stages.
// Every stage carries a valid bit and honours rst > flush > stall > advance.
// Optional feature macro: SEL_RANGE_CHECK_EN builds the sticky sel_err flag;
// without it sel_err is tied low.
module pipe_sel_mux
    import pipe_sel_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               N         = 4,
    parameter int               PIPE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              SEL_W     = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] x_flat,
    input  logic [SEL_W-1:0]   select,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [WIDTH-1:0]   y,
    output logic               out_valid,
    output logic               sel_err
);

    localparam int G = group_count(N);

    if (N < 2 || N > MAX_CH) begin : g_bad_n
        $error("pipe_sel_mux: N must be in 2..16");
    end
    if (PIPE != 0 && PIPE != 1) begin : g_bad_pipe
        $error("pipe_sel_mux: PIPE must be 0 or 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_sel_mux: WIDTH must be at least 1");
    end

    logic [3:0]                sel_ext;
    logic                      oor_c;
    logic [4*G-1:0][WIDTH-1:0] ch;
    logic [G-1:0][WIDTH-1:0]   grp_c;
    logic [G-1:0][WIDTH-1:0]   l2_src;
    logic [1:0]                l2_sel;
    logic [3:0][WIDTH-1:0]     l2_x;
    logic [WIDTH-1:0]          l2_y;
    logic [WIDTH-1:0]          y_q;
    logic                      vld_q;

    // Widen select to 4 bits so both tree levels can slice it uniformly.
    always_comb begin
        sel_ext              = '0;
        sel_ext[SEL_W-1:0]   = select;
    end

    assign oor_c = ({1'b0, sel_ext} >= 5'(N));

    for (genvar k = 0; k < 4*G; k++) begin : g_ch
        if (k < N) begin : g_live
            assign ch[k] = x_flat[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch[k] = RESET_VAL;
        end
    end

    // First level: each group resolves the low two select bits.
    for (genvar g = 0; g < G; g++) begin : g_grp
        sel_group4 #(.WIDTH(WIDTH)) u_grp (
            .x_i      (ch[4*g +: 4]),
            .lane_en_i({(4*g+3 < N), (4*g+2 < N), (4*g+1 < N), (4*g < N)}),
            .pad_i    (RESET_VAL),
            .sel_i    (sel_ext[1:0]),
            .y_o      (grp_c[g])
        );
    end

    for (genvar g = 0; g < 4; g++) begin : g_l2x
        if (g < G) begin : g_live
            assign l2_x[g] = l2_src[g];
        end else begin : g_pad
            assign l2_x[g] = RESET_VAL;
        end
    end

    // Second level: choose among the group results with the upper select bits.
    sel_group4 #(.WIDTH(WIDTH)) u_l2 (
        .x_i      (l2_x),
        .lane_en_i({(G > 3), (G > 2), (G > 1), 1'b1}),
        .pad_i    (RESET_VAL),
        .sel_i    (l2_sel),
        .y_o      (l2_y)
    );

    if (PIPE == 0) begin : g_pipe0
        logic [WIDTH-1:0] y_d;

        assign l2_src = grp_c;
        assign l2_sel = sel_ext[3:2];

        // Bubbles and out-of-range selects both present RESET_VAL.
        always_comb begin
            y_d = RESET_VAL;
            if (in_valid && !oor_c) begin
                y_d = l2_y;
            end
        end

        // Single output stage.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                y_q   <= RESET_VAL;
                vld_q <= 1'b0;
            end else if (!stall) begin
                y_q   <= y_d;
                vld_q <= in_valid;
            end
        end
    end else begin : g_pipe1
        logic [G-1:0][WIDTH-1:0] grp_q, grp_d;
        logic [1:0]              gsel_q, gsel_d;
        stage_ctrl_t             ctrl_q, ctrl_d;
        logic [WIDTH-1:0]        y_d;

        assign l2_src = grp_q;
        assign l2_sel = gsel_q;

        // Next-state for stage A (group capture) and stage B (final pick).
        always_comb begin
            ctrl_d.valid = in_valid;
            ctrl_d.oor   = in_valid & oor_c;
            gsel_d       = in_valid ? sel_ext[3:2] : 2'b00;
            for (int g = 0; g < G; g++) begin
                grp_d[g] = in_valid ? grp_c[g] : RESET_VAL;
            end
            y_d = RESET_VAL;
            if (ctrl_q.valid && !ctrl_q.oor) begin
                y_d = l2_y;
            end
        end

        // Stage A: group data, group index and control.
        always_ff @(posedge clk) begin
            if (rst) begin
                grp_q  <= '0;
                gsel_q <= '0;
                ctrl_q <= '0;
            end else if (flush) begin
                ctrl_q <= '0;
            end else if (!stall) begin
                grp_q  <= grp_d;
                gsel_q <= gsel_d;
                ctrl_q <= ctrl_d;
            end
        end

        // Stage B: output register.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                y_q   <= RESET_VAL;
                vld_q <= 1'b0;
            end else if (!stall) begin
                y_q   <= y_d;
                vld_q <= ctrl_q.valid;
            end
        end
    end

    assign y         = y_q;
    assign out_valid = vld_q;

`ifdef SEL_RANGE_CHECK_EN
    logic sel_err_q;

    // Sticky until rst; only accepted items can raise it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (!flush && !stall && in_valid && oor_c) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Bench for pipe_sel_mux: N=6, WIDTH=32, one instance per PIPE setting,
// both fed from the same stimulus and checked against an item-level model.
module tb_pipe_sel_mux;

    localparam int          W   = 32;
    localparam int          N   = 6;
    localparam logic [W-1:0] RV = 32'hDEAD_0000;
`ifdef SEL_RANGE_CHECK_EN
    localparam logic [W-1:0] CHK = 32'd1;
`else
    localparam logic [W-1:0] CHK = 32'd0;
`endif

    logic           clk;
    logic           rst;
    logic [N*W-1:0] x_flat;
    logic [2:0]     select;
    logic           in_valid;
    logic           stall;
    logic           flush;
    logic [W-1:0]   y0, y1;
    logic           v0, v1, e0, e1;

    int checks   = 0;
    int failures = 0;

    pipe_sel_mux #(.WIDTH(W), .N(N), .PIPE(0), .RESET_VAL(RV)) dut0 (
        .clk(clk), .rst(rst), .x_flat(x_flat), .select(select),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .y(y0), .out_valid(v0), .sel_err(e0)
    );

    pipe_sel_mux #(.WIDTH(W), .N(N), .PIPE(1), .RESET_VAL(RV)) dut1 (
        .clk(clk), .rst(rst), .x_flat(x_flat), .select(select),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .y(y1), .out_valid(v1), .sel_err(e1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_x(input logic [W-1:0] base);
        for (int k = 0; k < N; k++) begin
            x_flat[k*W +: W] = base + W'(k);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Item-level model: {valid, data} of what an accepted input must produce.
    function automatic logic [W:0] model_item();
        if (!in_valid) return {1'b0, RV};
        if (int'(select) >= N) return {1'b1, RV};
        return {1'b1, x_flat[int'(select)*W +: W]};
    endfunction

    logic [W:0] m0, m1a, m1b;
    logic       merr;
    bit         ready = 1'b0;

    // Model: latency-1 and latency-2 delay lines of items, cleared by rst/flush.
    always @(posedge clk) begin
        if (rst) begin
            m0    <= {1'b0, RV};
            m1a   <= {1'b0, RV};
            m1b   <= {1'b0, RV};
            merr  <= 1'b0;
            ready <= 1'b1;
        end else if (flush) begin
            m0  <= {1'b0, RV};
            m1a <= {1'b0, RV};
            m1b <= {1'b0, RV};
        end else if (!stall) begin
            m0  <= model_item();
            m1a <= model_item();
            m1b <= m1a;
            if (CHK[0] && in_valid && int'(select) >= N) merr <= 1'b1;
        end
    end

    // Compare every cycle once the design has seen reset.
    always @(negedge clk) begin
        if (ready) begin
            check("p0_y",   y0,      m0[W-1:0]);
            check("p0_vld", W'(v0),  W'(m0[W]));
            check("p0_err", W'(e0),  W'(merr));
            check("p1_y",   y1,      m1b[W-1:0]);
            check("p1_vld", W'(v1),  W'(m1b[W]));
            check("p1_err", W'(e1),  W'(merr));
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; select = 3'd3; stall = 1'b0; flush = 1'b0;
        set_x(32'h0000_5000);

        // Reset held two cycles with live inputs.
        step();
        check("rst_y0", y0, RV);
        check("rst_v0", W'(v0), '0);
        check("rst_y1", y1, RV);
        check("rst_v1", W'(v1), '0);
        check("rst_e0", W'(e0), '0);
        select = 3'd5;
        step();
        check("rst2_v1", W'(v1), '0);

        // Sweep 0..5 back to back.
        rst = 1'b0;
        set_x(32'h0000_00A0);
        for (int i = 0; i < 6; i++) begin
            select = 3'(i);
            step();
            check("sweep_y0", y0, 32'hA0 + W'(i));
            check("sweep_v0", W'(v0), 32'd1);
            if (i == 0) check("sweep_lat_v1", W'(v1), '0);
            else begin
                check("sweep_y1", y1, 32'hA0 + W'(i - 1));
                check("sweep_v1", W'(v1), 32'd1);
            end
        end
        in_valid = 1'b0;
        step();
        check("sweep_last_y1", y1, 32'hA5);
        check("sweep_last_v1", W'(v1), 32'd1);
        check("bubble_y0", y0, RV);

        // Stall for three cycles while the channels change.
        in_valid = 1'b1; select = 3'd2;
        step();
        check("stall_pre_y0", y0, 32'hA2);
        stall = 1'b1; select = 3'd5;
        set_x(32'h0000_00B0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_y0", y0, 32'hA2);
            check("stall_hold_v0", W'(v0), 32'd1);
            check("stall_hold_v1", W'(v1), '0);
        end
        stall = 1'b0;
        step();
        check("stall_next_y0", y0, 32'hB5);
        check("stall_late_y1", y1, 32'hA2);

        // Flush wins over stall with two items in flight.
        select = 3'd1;
        step();
        select = 3'd3;
        step();
        check("pre_flush_y1", y1, 32'hB1);
        flush = 1'b1; stall = 1'b1; select = 3'd0;
        step();
        check("flush_v0", W'(v0), '0);
        check("flush_y0", y0, RV);
        check("flush_v1", W'(v1), '0);
        check("flush_y1", y1, RV);
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("flush_gone_v1", W'(v1), '0);
        end

        // Out-of-range: stalled and flushed ones must not count.
        in_valid = 1'b1; select = 3'd6; stall = 1'b1;
        step();
        check("oor_stalled_e0", W'(e0), '0);
        stall = 1'b0; flush = 1'b1;
        step();
        check("oor_flushed_e0", W'(e0), '0);
        flush = 1'b0; select = 3'd7;
        step();
        check("oor_y0", y0, RV);
        check("oor_v0", W'(v0), 32'd1);
        check("oor_e0", W'(e0), CHK);
        in_valid = 1'b0;
        step();
        check("oor_y1", y1, RV);
        check("oor_v1", W'(v1), 32'd1);
        repeat (3) step();
        check("oor_sticky_e0", W'(e0), CHK);
        check("oor_sticky_e1", W'(e1), CHK);

        // Reset mid-stream.
        in_valid = 1'b1; select = 3'd4;
        step();
        rst = 1'b1;
        step();
        check("midrst_v0", W'(v0), '0);
        check("midrst_v1", W'(v1), '0);
        check("midrst_e0", W'(e0), '0);
        rst = 1'b0;

        // Alternating bubbles on channel 1.
        set_x(32'h0000_00A0);
        select = 3'd1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            step();
            if (i % 2 == 0) begin
                check("bub_y0", y0, 32'hA1);
                check("bub_v0", W'(v0), 32'd1);
            end else begin
                check("bub_y0", y0, RV);
                check("bub_v0", W'(v0), '0);
            end
        end

        // Mixed traffic against the model.
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < N; k++) x_flat[k*W +: W] = $urandom;
            in_valid = ($urandom_range(0, 3) != 0);
            select   = 3'($urandom_range(0, 7));
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            step();
        end
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
